// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry saturating counters.
// IF looks up the fetch PC combinationally; ID writes resolved branches back.
// Replacement is round-robin per set once every way is valid.
// Optional statistics counters are compiled in with the BTB_STATS_EN macro.
module btb_assoc #(
  parameter int PC_W  = 32,
  parameter int SETS  = 32,
  parameter int WAYS  = 2,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic            pred_hit,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            inv_all
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_allocs
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  // Entry storage, one element per set/way
  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAYS-1:0]  valid_d  [SETS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [TAG_W-1:0] tag_d    [SETS][WAYS];
  logic [PC_W-1:0]  target_q [SETS][WAYS];
  logic [PC_W-1:0]  target_d [SETS][WAYS];
  logic [CNT_W-1:0] cnt_q    [SETS][WAYS];
  logic [CNT_W-1:0] cnt_d    [SETS][WAYS];

  // Address split for lookup and update ports
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  assign lk_idx = pc[IDX_W+1:2];
  assign lk_tag = pc[PC_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];

  logic [WAYS-1:0] lk_match;
  logic [WAYS-1:0] up_match;
  logic [WAYS-1:0] up_free;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign lk_match[gi] = valid_q[lk_idx][gi] && (tag_q[lk_idx][gi] == lk_tag);
      assign up_match[gi] = valid_q[up_idx][gi] && (tag_q[up_idx][gi] == up_tag);
      assign up_free[gi]  = !valid_q[up_idx][gi];
    end
  endgenerate

  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;
  logic [PC_W-1:0]  pc_plus4;

  // Lookup: lowest matching way wins; outputs held at "no prediction" during reset
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_match[w]) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
    pc_plus4    = pc + PC_W'(4);
    pred_hit    = rst && lk_hit;
    pred_taken  = pred_hit && cnt_q[lk_idx][lk_way][CNT_W-1];
    pred_target = pred_taken ? target_q[lk_idx][lk_way] : pc_plus4;
  end

  logic             up_hit;
  logic [WAY_W-1:0] up_way;
  logic             free_found;
  logic [WAY_W-1:0] free_way;

  // Update-side way selection: matching way and lowest invalid way
  always_comb begin
    up_hit     = 1'b0;
    up_way     = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (up_match[w]) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (up_free[w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0] rr_cur;
  logic             rr_adv;

  generate
    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_q [SETS];
      logic [WAY_W-1:0] rr_d [SETS];

      assign rr_cur = rr_q[up_idx];

      // Round-robin pointer: cleared by invalidate, advanced on evictions
      always_comb begin
        rr_d = rr_q;
        if (inv_all) begin
          for (int s = 0; s < SETS; s++) rr_d[s] = '0;
        end else if (rr_adv) begin
          rr_d[up_idx] = rr_q[up_idx] + WAY_W'(1);
        end
      end

      // Round-robin pointer register
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
          rr_q <= rr_d;
        end
      end
    end else begin : g_no_rr
      assign rr_cur = '0;
    end
  endgenerate

  logic             do_alloc;
  logic [WAY_W-1:0] victim;

  // Next-state for entries: invalidate beats update; update is dropped in reset
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    do_alloc = 1'b0;
    rr_adv   = 1'b0;
    victim   = free_found ? free_way : rr_cur;
    if (inv_all) begin
      for (int s = 0; s < SETS; s++) valid_d[s] = '0;
    end else if (upd_valid && rst) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (cnt_q[up_idx][up_way] != CNT_MAX)
            cnt_d[up_idx][up_way] = cnt_q[up_idx][up_way] + CNT_W'(1);
          target_d[up_idx][up_way] = upd_target;
        end else if (cnt_q[up_idx][up_way] != '0) begin
          cnt_d[up_idx][up_way] = cnt_q[up_idx][up_way] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        do_alloc                 = 1'b1;
        rr_adv                   = !free_found;
        valid_d[up_idx][victim]  = 1'b1;
        tag_d[up_idx][victim]    = up_tag;
        target_d[up_idx][victim] = upd_target;
        cnt_d[up_idx][victim]    = CNT_WEAK;
      end
    end
  end

  // Entry registers; only valid bits need a reset value
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q    <= tag_d;
    target_q <= target_d;
    cnt_q    <= cnt_d;
  end

`ifdef BTB_STATS_EN
  logic [PC_W-1:0] pc_prev_q;
  logic [31:0]     lookups_q, lookups_d;
  logic [31:0]     hits_q, hits_d;
  logic [31:0]     allocs_q, allocs_d;

  // Statistics next-state: cleared on invalidate, otherwise count events
  always_comb begin
    lookups_d = lookups_q;
    hits_d    = hits_q;
    allocs_d  = allocs_q;
    if (inv_all) begin
      lookups_d = '0;
      hits_d    = '0;
      allocs_d  = '0;
    end else begin
      if (pc != pc_prev_q) lookups_d = lookups_q + 32'd1;
      if (pred_hit)        hits_d    = hits_q + 32'd1;
      if (do_alloc)        allocs_d  = allocs_q + 32'd1;
    end
  end

  // Statistics registers; previous PC is tracked even in reset
  always_ff @(posedge clk) begin
    pc_prev_q <= pc;
    if (!rst) begin
      lookups_q <= '0;
      hits_q    <= '0;
      allocs_q  <= '0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      allocs_q  <= allocs_d;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_hits    = hits_q;
  assign stat_allocs  = allocs_q;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc (default parameters: 32 sets, 2 ways, 2-bit counters).
// Stimulus pushes expected lookup results; a negedge monitor pops and compares.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        inv_all = 1'b0;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_allocs;
`endif

  btb_assoc #(.PC_W(32), .SETS(32), .WAYS(2), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_hit    (pred_hit),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .inv_all     (inv_all)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_hits   (stat_hits),
    .stat_allocs (stat_allocs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    bit          stat;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  bit   chk_en   = 1'b0;
  bit   fin_req  = 1'b0;
  bit   fin_done = 1'b0;
  int   n_chk    = 0;
  int   n_fail   = 0;

  // Monitor: compare DUT outputs against the scoreboard away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got an output with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        if (e.stat) begin
`ifdef BTB_STATS_EN
          n_chk++;
          if (stat_lookups !== 32'd0 || stat_hits !== 32'd0 || stat_allocs !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: got lookups=%0d hits=%0d allocs=%0d, required all 0",
                     e.name, stat_lookups, stat_hits, stat_allocs);
          end else begin
            $display("check %s: stats all zero", e.name);
          end
`endif
        end else begin
          n_chk++;
          if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.tgt) begin
            n_fail++;
            $display("FAIL %s: pc=%08h got hit=%0b taken=%0b target=%08h, required hit=%0b taken=%0b target=%08h",
                     e.name, e.pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
          end else begin
            $display("check %s: pc=%08h hit=%0b taken=%0b target=%08h",
                     e.name, e.pc, pred_hit, pred_taken, pred_target);
          end
        end
      end
    end
    if (fin_req && !fin_done) begin
      n_chk++;
      if (sb_q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", sb_q.size());
      end
      fin_done = 1'b1;
    end
  end

  // One clock cycle of stimulus; optionally queues an expected lookup result
  task automatic step(input bit r, input bit uv, input logic [31:0] upc,
                      input logic [31:0] utgt, input bit utk, input bit inv,
                      input logic [31:0] lpc, input bit chk, input string nm,
                      input bit eh, input bit et, input logic [31:0] etgt, input bit st);
    exp_t x;
    @(posedge clk);
    #1;
    rst        = r;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_target = utgt;
    upd_taken  = utk;
    inv_all    = inv;
    pc         = lpc;
    chk_en     = chk;
    if (chk) begin
      x.name  = nm;
      x.pc    = lpc;
      x.hit   = eh;
      x.taken = et;
      x.tgt   = etgt;
      x.stat  = st;
      sb_q.push_back(x);
    end
  endtask

  task automatic look(input string nm, input logic [31:0] lpc,
                      input bit eh, input bit et, input logic [31:0] etgt);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, lpc, 1'b1, nm, eh, et, etgt, 1'b0);
  endtask

  task automatic upd(input logic [31:0] upc, input logic [31:0] utgt, input bit utk);
    step(1'b1, 1'b1, upc, utgt, utk, 1'b0, 32'h0, 1'b0, "", 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset with an update pending: outputs forced, update dropped
    step(1'b0, 1'b1, 32'h100, 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, "reset_forced", 1'b0, 1'b0, 32'h104, 1'b0);
    step(1'b0, 1'b1, 32'h100, 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, "reset_forced2", 1'b0, 1'b0, 32'h104, 1'b0);
    look("after_reset_miss", 32'h100, 1'b0, 1'b0, 32'h104);

    // Allocation: same-cycle lookup sees pre-edge state
    step(1'b1, 1'b1, 32'h100, 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, "no_bypass", 1'b0, 1'b0, 32'h104, 1'b0);
    look("alloc_hit_weak_taken", 32'h100, 1'b1, 1'b1, 32'h40);

    // Counter walk down: 2 -> 1 -> 0 -> 0
    step(1'b1, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1, "pre_edge_cnt2", 1'b1, 1'b1, 32'h40, 1'b0);
    look("cnt1_not_taken", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 32'h0, 1'b0);
    look("cnt0_not_taken", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 32'h0, 1'b0);

    // Counter walk up with target refresh: 0 -> 1 -> 2 -> 3 -> 3
    upd(32'h100, 32'h44, 1'b1);
    look("cnt_floor_then_1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 32'h48, 1'b1);
    look("cnt2_new_target", 32'h100, 1'b1, 1'b1, 32'h48);
    upd(32'h100, 32'h48, 1'b1);
    upd(32'h100, 32'h48, 1'b1);
    look("cnt_sat_taken", 32'h100, 1'b1, 1'b1, 32'h48);
    upd(32'h100, 32'h0, 1'b0);
    look("cnt_sat_minus1", 32'h100, 1'b1, 1'b1, 32'h48);
    upd(32'h100, 32'h0, 1'b0);
    look("cnt1_again", 32'h100, 1'b1, 1'b0, 32'h104);

    // Not-taken miss leaves state untouched
    upd(32'h180, 32'h80, 1'b0);
    look("nt_miss_no_alloc", 32'h180, 1'b0, 1'b0, 32'h184);

    // Fill set 0, then evict way 0 and way 1 in turn
    upd(32'h180, 32'h80, 1'b1);
    look("way1_fill", 32'h180, 1'b1, 1'b1, 32'h80);
    look("way0_kept", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h200, 32'hC0, 1'b1);
    look("evict_way0_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("evict_way0_keep", 32'h180, 1'b1, 1'b1, 32'h80);
    look("evict_way0_new", 32'h200, 1'b1, 1'b1, 32'hC0);
    upd(32'h280, 32'hD0, 1'b1);
    look("evict_way1_old", 32'h180, 1'b0, 1'b0, 32'h184);
    look("evict_way1_keep", 32'h200, 1'b1, 1'b1, 32'hC0);
    look("evict_way1_new", 32'h280, 1'b1, 1'b1, 32'hD0);

    // Other set and pc+4 wraparound
    look("other_set_miss", 32'h104, 1'b0, 1'b0, 32'h108);
    look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Invalidate beats a simultaneous update; lookup that cycle is pre-edge
    step(1'b1, 1'b1, 32'h300, 32'hE0, 1'b1, 1'b1, 32'h200, 1'b1, "inv_pre_edge", 1'b1, 1'b1, 32'hC0, 1'b0);
`ifdef BTB_STATS_EN
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h200, 1'b1, "stats_cleared", 1'b0, 1'b0, 32'h0, 1'b1);
`endif
    look("inv_miss_a", 32'h200, 1'b0, 1'b0, 32'h204);
    look("inv_miss_b", 32'h280, 1'b0, 1'b0, 32'h284);
    look("inv_upd_dropped", 32'h300, 1'b0, 1'b0, 32'h304);

    // After invalidate, round-robin restarts at way 0
    upd(32'h100, 32'h10, 1'b1);
    upd(32'h180, 32'h20, 1'b1);
    upd(32'h200, 32'h30, 1'b1);
    look("rr_restart_evicted", 32'h100, 1'b0, 1'b0, 32'h104);
    look("rr_restart_kept", 32'h180, 1'b1, 1'b1, 32'h20);

    // Drain and summarise
    @(posedge clk);
    #1;
    chk_en    = 1'b0;
    upd_valid = 1'b0;
    inv_all   = 1'b0;
    fin_req   = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) @(posedge clk);
    if (!fin_done) begin
      $display("FAIL monitor_timeout: got no drain check, required one within 10 cycles");
      $fatal(1, "monitor did not respond");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer for the RV32I pipeline; successor of the single-table direct-mapped BTB.
- IF stage performs a combinational lookup on the fetch PC and receives a predicted next PC.
- ID stage, where the branch is resolved, writes updates back.
- Adds per-entry saturating counters of configurable width, N-way sets with round-robin replacement, and a bulk-invalidate input.

Parameters:
- PC_W, 32, PC and target width in bits.
- SETS, 32, number of sets; power of two, at least 2.
- WAYS, 2, ways per set; power of two, 1..8.
- CNT_W, 2, prediction counter width in bits, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- pc  in  PC_W  fetch PC for lookup.
- pred_taken  out  1  lookup hit and counter MSB = 1.
- pred_target  out  PC_W  stored target when pred_taken = 1, otherwise pc+4.
- pred_hit  out  1  tag match in a valid way, regardless of direction.
- upd_valid  in  1  ID stage resolved a branch or jump this cycle.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_target  in  PC_W  resolved target address.
- upd_taken  in  1  resolved direction.
- inv_all  in  1  clear all valid bits.

Behaviour:
- Address split: IDX_W = log2(SETS). Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2]. pc[1:0] is ignored. The same split applies to upd_pc.
- Entry contents: valid, tag, target, cnt[CNT_W-1:0]. Each set also holds a round-robin pointer rr[log2(WAYS)-1:0]; the pointer is absent when WAYS = 1.
- Lookup (combinational, zero latency):
  - hit = valid and tag equal in some way.
  - At most one way may match. If more than one matches, the lowest way wins.
  - pred_taken = hit and cnt[CNT_W-1].
  - pred_target = target of the matching way when pred_taken = 1, otherwise pc+4 (mod 2^PC_W).
- Lookup always sees pre-edge state. An update to the same set in the same cycle is not bypassed.
- Update is registered and takes effect at the clk edge when upd_valid = 1.
  - Hit in way w, upd_taken = 1: cnt saturating increment (max 2^CNT_W-1); target <= upd_target.
  - Hit in way w, upd_taken = 0: cnt saturating decrement (min 0). The entry stays valid and target is unchanged.
  - Miss, upd_taken = 1: allocate. The victim is the lowest-numbered invalid way; if all ways are valid, the victim is way rr and rr <= rr+1 (wrapping). The victim is written with valid = 1, the tag, upd_target, and cnt = 2^(CNT_W-1) (weakly taken). rr advances only on allocations that evict a valid entry.
  - Miss, upd_taken = 0: no state change.
- Reset (rst = 0 at an edge):
  - All valid bits <= 0 and all rr <= 0.
  - Target, tag and cnt contents are don't-care.
  - While rst = 0, outputs are forced to pred_taken = 0, pred_hit = 0, pred_target = pc+4.
  - An update in the same cycle as reset is dropped.
- inv_all = 1 at an edge:
  - All valid bits <= 0 and all rr <= 0.
  - It takes priority over a simultaneous upd_valid, which is dropped.
  - Lookup during that cycle still uses pre-edge state.
- Reset with an update pending: no partial writes. An edge either fully applies the update or drops it.
- Storage: flops, or distributed RAM with a synchronous write and asynchronous read.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds three outputs, each 32 bits wide. All three reset to 0 and clear on inv_all, and all wrap at 2^32.
  - stat_lookups increments every cycle with rst = 1 and pc changing from the previous cycle.
  - stat_hits increments on cycles with pred_hit = 1.
  - stat_allocs increments on each allocation.
- Undefined: none of these ports or registers exist, and the core behaviour is identical.

Test Plan:
- Reset, then lookup pc = 0x100 → pred_hit = 0, pred_taken = 0, pred_target = 0x104.
- Update pc = 0x100, target = 0x40, taken; next cycle lookup 0x100 → pred_hit = 1, pred_taken = 1, pred_target = 0x40, cnt = 2 (CNT_W = 2).
- Two not-taken updates to 0x100 → cnt goes 2→1→0; lookup gives pred_hit = 1, pred_taken = 0, pred_target = 0x104. Three taken updates → cnt = 3, with no saturation overflow on a fourth.
- SETS = 32, WAYS = 2: allocate 0x100, 0x180, 0x200 (same index 0); ways fill 0, 1, then 0x200 evicts way 0 (rr = 0→1) → 0x100 misses, 0x180 and 0x200 hit; a fourth alias evicts way 1.
- Update 0x100 and look up 0x100 in the same cycle → the lookup misses; the following cycle it hits.
- inv_all asserted together with upd_valid on a new PC → all lookups miss afterwards and the update is not applied; with BTB_STATS_EN, the counters read 0.
